// File: rtl/ex_stage_if.sv
// Execute-stage bundle: operation in, registered result and flags out,
// each side guarded by its own valid/ready pair.
interface ex_stage_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alu_op;
    logic             alu_src;
    logic             mem_read;
    logic             mem_write;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] imm;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] read_data;
    logic             zero;
    logic             neg;
    logic             carry;
    logic             overflow;
    logic             addr_err;

    modport master (
        output in_valid, alu_op, alu_src,
        output mem_read, mem_write,
        output rd1, rd2, imm, out_ready,
        input  in_ready, out_valid,
        input  result, read_data,
        input  zero, neg, carry, overflow,
        input  addr_err
    );

    modport slave (
        input  in_valid, alu_op, alu_src,
        input  mem_read, mem_write,
        input  rd1, rd2, imm, out_ready,
        output in_ready, out_valid,
        output result, read_data,
        output zero, neg, carry, overflow,
        output addr_err
    );
endinterface

// File: rtl/ex_stage.sv
// Pipelined execute stage: ALU with flags plus word-addressed data memory,
// one op per cycle, results registered and held under back-pressure.
module ex_stage #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 16
) (
    input logic      clock,
    input logic      reset,
    ex_stage_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int M     = WIDTH - 1;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic [WIDTH:0]   sum;
    logic             c;
    logic             v;

    logic                 accept;
    logic                 oob;
    logic [ADDR_BITS-1:0] maddr;

    logic             valid_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] rdata_q;
    logic             zero_q;
    logic             neg_q;
    logic             carry_q;
    logic             ovf_q;
    logic             aerr_q;

    // Not reset: contents survive reset, boot image preloaded.
    logic [WIDTH-1:0] mem [DEPTH] = '{
        0: WIDTH'(0),  1: WIDTH'(4),  2: WIDTH'(30),
        3: WIDTH'(19), 4: WIDTH'(6),  5: WIDTH'(10),
        default: '0
    };

    assign bus.in_ready = !reset && (!valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign oob          = |(bus.rd1 >> ADDR_BITS);
    assign maddr        = bus.rd1[ADDR_BITS-1:0];

    always_comb begin
        a   = bus.alu_src ? bus.imm : bus.rd2;
        b   = bus.rd1;
        sum = '0;
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        unique case (bus.alu_op)
            3'b000: res = a;
            3'b001: begin
                sum = {1'b0, a} + {1'b0, b};
                res = sum[M:0];
                c   = sum[WIDTH];
                v   = (a[M] == b[M]) && (res[M] != a[M]);
            end
            3'b010: begin
                sum = {1'b0, b} + (WIDTH+1)'(1);
                res = sum[M:0];
                c   = sum[WIDTH];
                v   = !b[M] && res[M];
            end
            3'b011: begin
                res = '0 - b;
                c   = (b == '0);
                v   = b[M] && res[M];
            end
            3'b100: begin
                // Borrow lands in the top bit; carry is its inverse.
                sum = {1'b0, a} - {1'b0, b};
                res = sum[M:0];
                c   = !sum[WIDTH];
                v   = (a[M] != b[M]) && (res[M] != a[M]);
            end
            3'b101: res = a & b;
            3'b110: res = a | b;
            3'b111: res = a ^ b;
        endcase
    end

    always_ff @(posedge clock) begin
        if (accept && bus.mem_write && !oob)
            mem[maddr] <= bus.rd2;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            rdata_q  <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            aerr_q   <= 1'b0;
        end else if (accept) begin
            valid_q  <= 1'b1;
            result_q <= res;
            rdata_q  <= (bus.mem_read && !oob) ?
                        mem[maddr] : '0;
            zero_q   <= (res == '0);
            neg_q    <= res[M];
            carry_q  <= c;
            ovf_q    <= v;
            aerr_q   <= oob &&
                        (bus.mem_read || bus.mem_write);
        end else if (bus.out_ready) begin
            valid_q  <= 1'b0;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.result    = result_q;
    assign bus.read_data = rdata_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = ovf_q;
    assign bus.addr_err  = aerr_q;
endmodule
